// File: rtl/jam_cost_responder.sv
// Cost-table responder: holds the 8x8 worker/job cost matrix, serves W/J lookups
// and captures the searcher's result, or flags a search that never finishes.
module jam_cost_responder #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ld_valid,
   input  logic [6:0]  ld_data,
   output logic        ld_ready,
   input  logic [2:0]  W,
   input  logic [2:0]  J,
   output logic [6:0]  Cost,
   input  logic        Valid,
   input  logic [3:0]  MatchCount,
   input  logic [9:0]  MinCost,
   output logic        table_ready,
   output logic        res_valid,
   output logic [3:0]  res_count,
   output logic [9:0]  res_min,
   output logic [19:0] cyc_count,
   output logic        timeout
);

   localparam int unsigned COST_W  = 7;
   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned DEPTH   = 64;
   localparam int unsigned CYC_W   = 20;
   localparam int unsigned COUNT_W = 4;
   localparam int unsigned MIN_W   = 10;

   localparam logic [CYC_W-1:0]  CYC_MAX  = {CYC_W{1'b1}};
   localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_END = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_SERVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    ld_addr_q, ld_addr_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic                 res_valid_q, res_valid_d;
   logic [COUNT_W-1:0]   res_count_q, res_count_d;
   logic [MIN_W-1:0]     res_min_q, res_min_d;
   logic                 timeout_q, timeout_d;
   logic                 mem_we;
   logic [COST_W-1:0]    mem [DEPTH];

   // Cost storage; contents survive reset and are rewritten by each load.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[ld_addr_q] <= ld_data;
      end
   end

   // State and result registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_LOAD;
         ld_addr_q   <= '0;
         cyc_q       <= '0;
         res_valid_q <= 1'b0;
         res_count_q <= '0;
         res_min_q   <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_addr_q   <= ld_addr_d;
         cyc_q       <= cyc_d;
         res_valid_q <= res_valid_d;
         res_count_q <= res_count_d;
         res_min_q   <= res_min_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic; a Valid in the final timeout cycle takes priority.
   always_comb begin
      state_d     = state_q;
      ld_addr_d   = ld_addr_q;
      cyc_d       = cyc_q;
      res_valid_d = res_valid_q;
      res_count_d = res_count_q;
      res_min_d   = res_min_q;
      timeout_d   = timeout_q;
      mem_we      = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (ld_valid) begin
               mem_we    = 1'b1;
               ld_addr_d = ld_addr_q + ADDR_W'(1);
               if (ld_addr_q == ADDR_END) begin
                  state_d = S_SERVE;
               end
            end
         end
         S_SERVE: begin
            if (cyc_q != CYC_MAX) begin
               cyc_d = cyc_q + CYC_W'(1);
            end
            if (Valid) begin
               res_valid_d = 1'b1;
               res_count_d = MatchCount;
               res_min_d   = MinCost;
               state_d     = S_DONE;
            end else if (cyc_q == CYC_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   assign ld_ready    = (state_q == S_LOAD);
   assign table_ready = (state_q != S_LOAD);
   assign Cost        = (state_q == S_LOAD) ? COST_W'(0) : mem[{W, J}];
   assign res_valid   = res_valid_q;
   assign res_count   = res_count_q;
   assign res_min     = res_min_q;
   assign cyc_count   = cyc_q;
   assign timeout     = timeout_q;

endmodule
